// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decode-stage operands, destination and
// execute control, with stall (hold), flush (bubble) and a valid flag.
// Optional bubble counter is built when ID_EX_BUBBLE_CNT_EN is defined;
// otherwise bubble_cnt is tied to zero and no counter flops exist.
module id_ex_register (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_id,
    input  logic [2:0]  Si_id,
    input  logic [31:0] PA_id,
    input  logic [31:0] PB_id,
    input  logic [11:0] imm12_I_id,
    input  logic [11:0] imm12_S_id,
    input  logic [19:0] imm20_id,
    input  logic [31:0] PC_id,
    input  logic [4:0]  rd_id,
    input  logic [9:0]  ctrl_id,
    output logic [2:0]  Si_ex,
    output logic [31:0] PA_ex,
    output logic [31:0] PB_ex,
    output logic [11:0] imm12_I_ex,
    output logic [11:0] imm12_S_ex,
    output logic [19:0] imm20_ex,
    output logic [31:0] PC_ex,
    output logic [4:0]  rd_ex,
    output logic [9:0]  ctrl_ex,
    output logic        valid_ex,
    output logic [15:0] bubble_cnt
);

    // A bubble enters EX when the register updates (flush or plain load)
    // and the resulting instruction is not valid. Held cycles never count.
    logic bubble_in;
    assign bubble_in = flush | (~stall & ~valid_id);

    // Pipeline register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            Si_ex      <= 3'b000;
            PA_ex      <= 32'h0;
            PB_ex      <= 32'h0;
            imm12_I_ex <= 12'h0;
            imm12_S_ex <= 12'h0;
            imm20_ex   <= 20'h0;
            PC_ex      <= 32'h0;
            rd_ex      <= 5'h0;
            ctrl_ex    <= 10'h0;
            valid_ex   <= 1'b0;
        end else if (!stall) begin
            Si_ex      <= Si_id;
            PA_ex      <= PA_id;
            PB_ex      <= PB_id;
            imm12_I_ex <= imm12_I_id;
            imm12_S_ex <= imm12_S_id;
            imm20_ex   <= imm20_id;
            PC_ex      <= PC_id;
            rd_ex      <= rd_id;
            ctrl_ex    <= ctrl_id;
            valid_ex   <= valid_id;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bcnt;

    // Free-running bubble count, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)
            bcnt <= 16'h0;
        else if (bubble_in)
            bcnt <= bcnt + 16'h1;
    end

    assign bubble_cnt = bcnt;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_in;
    assign bubble_cnt    = 16'h0000;
`endif

endmodule
